fifo_status_monitor: RTL and testbench

//  Status source for the FIFO-control FSM. Tracks occupancy of the five data FIFOs (main, VC0, VC1, D0, D1)

---
 rtl/fifo_status_monitor.sv | 184 ++++++++++++++++++
 tb/tb_fifo_status_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_status_monitor.sv
// -----------------------------------------------------------------------------
// fifo_status_monitor
//
// Status source for the FIFO-control FSM. Tracks the occupancy of five data
// FIFOs (bit 0 = main, 1 = VC0, 2 = VC1, 3 = D0, 4 = D1) from their push/pop
// strobes. Reports per-FIFO empty, sticky error, almost-empty, almost-full and
// pause flags. Every flag is registered and computed from the next-state
// occupancy, so a strobe sampled at edge N is reflected right after edge N.
//
// Parameters
//   DEPTH  entries per FIFO (1..31)
//   CNT_W  occupancy counter width; must hold DEPTH
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   push[4:0]     in   per-FIFO write strobe
//   pop[4:0]      in   per-FIFO read strobe
//   err_clr       in   pulse; clears all sticky error bits
//   *_l / *_h     in   per-FIFO low/high thresholds (5-bit, sampled every cycle)
//   empties       out  occupancy == 0
//   errors        out  sticky overflow/underflow flag
//   almost_empty  out  occupancy <= low threshold
//   almost_full   out  occupancy >= high threshold
//   pause         out  back-pressure request to the FIFO writer
//
// Configuration macro
//   FIFO_MON_HYST_EN  defined: pause is a per-FIFO RUN/HOLD hysteresis FSM
//                     (enter HOLD at >= high, leave at <= low).
//                     undefined: pause equals almost_full.
// -----------------------------------------------------------------------------
module fifo_status_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] push,
  input  logic [4:0] pop,
  input  logic       err_clr,
  input  logic [4:0] mf_l,
  input  logic [4:0] mf_h,
  input  logic [4:0] vco_l,
  input  logic [4:0] vco_h,
  input  logic [4:0] vc1_l,
  input  logic [4:0] vc1_h,
  input  logic [4:0] do_l,
  input  logic [4:0] do_h,
  input  logic [4:0] d1_l,
  input  logic [4:0] d1_h,
  output logic [4:0] empties,
  output logic [4:0] errors,
  output logic [4:0] almost_empty,
  output logic [4:0] almost_full,
  output logic [4:0] pause
);

  localparam int N     = 5;
  localparam int THR_W = 5;
  // Thresholds are 5-bit; compare in a width that holds both operands so a
  // narrow counter never truncates a threshold.
  localparam int CMP_W = (CNT_W > THR_W) ? CNT_W : THR_W;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] occ_q [N];
  logic [CNT_W-1:0] occ_d [N];

  logic [THR_W-1:0] lo_thr [N];
  logic [THR_W-1:0] hi_thr [N];
  logic [CMP_W-1:0] occ_x  [N];
  logic [CMP_W-1:0] lo_x   [N];
  logic [CMP_W-1:0] hi_x   [N];

  logic [N-1:0] new_err;
  logic [N-1:0] err_q,   err_d;
  logic [N-1:0] empty_q, empty_d;
  logic [N-1:0] ae_q,    ae_d;
  logic [N-1:0] af_q,    af_d;
  logic [N-1:0] pause_q, pause_d;

  // Gather per-FIFO thresholds in bit-index order.
  always_comb begin
    lo_thr[0] = mf_l;  hi_thr[0] = mf_h;
    lo_thr[1] = vco_l; hi_thr[1] = vco_h;
    lo_thr[2] = vc1_l; hi_thr[2] = vc1_h;
    lo_thr[3] = do_l;  hi_thr[3] = do_h;
    lo_thr[4] = d1_l;  hi_thr[4] = d1_h;
  end

  // Occupancy next state, error detection and flag derivation.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    new_err = '0;
    empty_d = '0;
    ae_d    = '0;
    af_d    = '0;
    for (int i = 0; i < N; i++) begin
      occ_d[i] = occ_q[i];
      unique case ({push[i], pop[i]})
        2'b10: begin
          if (occ_q[i] == DEPTH_C) new_err[i] = 1'b1;    // overflow, hold count
          else                     occ_d[i]   = occ_q[i] + ONE_C;
        end
        2'b01: begin
          if (occ_q[i] == '0) new_err[i] = 1'b1;         // underflow, hold count
          else                occ_d[i]   = occ_q[i] - ONE_C;
        end
        default: ;                                       // idle or simultaneous push/pop
      endcase

      occ_x[i]   = CMP_W'(occ_d[i]);
      lo_x[i]    = CMP_W'(lo_thr[i]);
      hi_x[i]    = CMP_W'(hi_thr[i]);
      empty_d[i] = (occ_d[i] == '0);
      ae_d[i]    = (occ_x[i] <= lo_x[i]);
      af_d[i]    = (occ_x[i] >= hi_x[i]);
    end
    // A fresh error in the clearing cycle survives the clear.
    err_d = (err_q & ~{N{err_clr}}) | new_err;
  end

`ifdef FIFO_MON_HYST_EN
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} pause_state_e;

  pause_state_e ps_q [N];
  pause_state_e ps_d [N];

  always_comb begin
    pause_d = '0;
    for (int i = 0; i < N; i++) begin
      ps_d[i] = ps_q[i];
      unique case (ps_q[i])
        RUN:     if (occ_x[i] >= hi_x[i]) ps_d[i] = HOLD;
        HOLD:    if (occ_x[i] <= lo_x[i]) ps_d[i] = RUN;
        default: ps_d[i] = RUN;
      endcase
      pause_d[i] = (ps_d[i] == HOLD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) ps_q[i] <= RUN;
    end else begin
      for (int i = 0; i < N; i++) ps_q[i] <= ps_d[i];
    end
  end
`else
  always_comb begin
    pause_d = af_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // The occupancy array is a handful of flops, not a RAM, so every
      // entry is reset; an in-flight strobe during reset is dropped.
      for (int i = 0; i < N; i++) occ_q[i] <= '0;
      err_q   <= '0;
      empty_q <= '1;
      ae_q    <= '1;
      af_q    <= '0;
      pause_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) occ_q[i] <= occ_d[i];
      err_q   <= err_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      pause_q <= pause_d;
    end
  end

  assign empties      = empty_q;
  assign errors       = err_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign pause        = pause_q;

endmodule

// File: tb/tb_fifo_status_monitor.sv
// -----------------------------------------------------------------------------
// tb_fifo_status_monitor
//
// Directed self-checking bench for fifo_status_monitor (DEPTH = 16). Inputs
// change 1 time unit after a rising edge; outputs are sampled at that point,
// i.e. they show the effect of the strobes taken at the preceding edge.
// Expected pause behaviour follows FIFO_MON_HYST_EN when it is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_status_monitor;

`ifdef FIFO_MON_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] push, pop;
  logic       err_clr;
  logic [4:0] mf_l, mf_h, vco_l, vco_h, vc1_l, vc1_h, do_l, do_h, d1_l, d1_h;
  logic [4:0] empties, errors, almost_empty, almost_full, pause;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_status_monitor #(.DEPTH(16), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .err_clr      (err_clr),
    .mf_l         (mf_l),
    .mf_h         (mf_h),
    .vco_l        (vco_l),
    .vco_h        (vco_h),
    .vc1_l        (vc1_l),
    .vc1_h        (vc1_h),
    .do_l         (do_l),
    .do_h         (do_h),
    .d1_l         (d1_l),
    .d1_h         (d1_h),
    .empties      (empties),
    .errors       (errors),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .pause        (pause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply push/pop for n cycles, then return the strobes to idle.
  task automatic strobe(input logic [4:0] pu, input logic [4:0] po, input int n);
    for (int k = 0; k < n; k++) begin
      push = pu;
      pop  = po;
      tick();
    end
    push = '0;
    pop  = '0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    push    = '0;
    pop     = '0;
    err_clr = 1'b0;
    mf_l  = 5'd3; mf_h  = 5'd10;
    vco_l = 5'd2; vco_h = 5'd12;
    vc1_l = 5'd2; vc1_h = 5'd12;
    do_l  = 5'd2; do_h  = 5'd12;
    d1_l  = 5'd2; d1_h  = 5'd12;

    // ---------------- reset values ----------------
    #1 reset = 1'b1;
    #2;
    check("rst_empties",  empties,      5'b11111);
    check("rst_errors",   errors,       5'b00000);
    check("rst_ae",       almost_empty, 5'b11111);
    check("rst_af",       almost_full,  5'b00000);
    check("rst_pause",    pause,        5'b00000);
    tick();
    reset = 1'b0;

    // ---------------- 1: reset mid-run ----------------
    strobe(5'b00001, 5'b00000, 7);            // occ[0] = 7
    check("t1_fill_empties", empties, 5'b11110);
    strobe(5'b00000, 5'b01000, 1);            // underflow on D0
    check("t1_pre_err", errors, 5'b01000);
    push = 5'b00001;                           // in flight when reset hits
    #2 reset = 1'b1;
    #1;
    check("t1_async_empties", empties,      5'b11111);
    check("t1_async_errors",  errors,       5'b00000);
    check("t1_async_ae",      almost_empty, 5'b11111);
    check("t1_async_pause",   pause,        5'b00000);
    tick();                                    // push still high, must be dropped
    reset = 1'b0;
    push  = '0;
    check("t1_post_empties", empties, 5'b11111);
    strobe(5'b00000, 5'b00001, 1);             // occ[0] really 0 -> underflow
    check("t1_occ_zero_udf", errors, 5'b00001);
    clear_errors();
    check("t1_clr", errors, 5'b00000);

    // ---------------- 2: fill VC0 ----------------
    for (int k = 1; k <= 16; k++) begin
      strobe(5'b00010, 5'b00000, 1);
      if (k == 1)  check("t2_empty_fall", empties[1],      1'b0);
      if (k == 2)  check("t2_ae_at_low",  almost_empty[1], 1'b1);
      if (k == 3)  check("t2_ae_fall",    almost_empty[1], 1'b0);
      if (k == 11) check("t2_af_11",      almost_full[1],  1'b0);
      if (k == 12) check("t2_af_12",      almost_full[1],  1'b1);
      if (k == 16) check("t2_full_noerr", errors[1],       1'b0);
    end
    strobe(5'b00010, 5'b00000, 1);             // 17th push overflows
    check("t2_ovf", errors, 5'b00010);
    for (int k = 1; k <= 16; k++) begin
      strobe(5'b00000, 5'b00010, 1);
      if (k == 15) check("t2_drain_15", empties[1], 1'b0);
      if (k == 16) check("t2_drain_16", empties[1], 1'b1);
    end
    check("t2_sticky", errors, 5'b00010);
    clear_errors();

    // ---------------- 3: underflow, clear, clear vs new error ----------------
    strobe(5'b00000, 5'b01000, 1);
    check("t3_udf", errors, 5'b01000);
    clear_errors();
    check("t3_clr", errors, 5'b00000);
    strobe(5'b10000, 5'b00000, 16);            // D1 full
    check("t3_d1_af", almost_full[4], 1'b1);
    check("t3_d1_noerr", errors, 5'b00000);
    strobe(5'b00000, 5'b01000, 1);
    check("t3_udf_again", errors, 5'b01000);
    push    = 5'b10000;                        // overflow coincident with clear
    err_clr = 1'b1;
    tick();
    push    = '0;
    err_clr = 1'b0;
    check("t3_clr_vs_new", errors, 5'b10000);
    clear_errors();

    // ---------------- 4: simultaneous push/pop ----------------
    strobe(5'b00100, 5'b00100, 1);             // at occ 0
    check("t4_pp0_empty", empties[2], 1'b1);
    check("t4_pp0_err",   errors[2],  1'b0);
    strobe(5'b00100, 5'b00000, 16);
    strobe(5'b00100, 5'b00100, 1);             // at occ 16
    check("t4_pp16_err", errors[2],      1'b0);
    check("t4_pp16_af",  almost_full[2], 1'b1);
    strobe(5'b00100, 5'b00000, 1);             // still 16 -> overflow
    check("t4_still_full", errors[2], 1'b1);
    clear_errors();

    // ---------------- 5: pause (mf_l=3, mf_h=10) ----------------
    strobe(5'b00001, 5'b00000, 9);
    check("t5_pause_9",  pause[0], 1'b0);
    strobe(5'b00001, 5'b00000, 1);
    check("t5_pause_10", pause[0], 1'b1);
    strobe(5'b00000, 5'b00001, 1);
    check("t5_pause_d9", pause[0], HYST);
    strobe(5'b00000, 5'b00001, 5);
    check("t5_pause_d4", pause[0], HYST);
    strobe(5'b00000, 5'b00001, 1);
    check("t5_pause_d3", pause[0], 1'b0);

    // ---------------- 6: live threshold changes and boundaries ----------------
    d1_h = 5'd9;
    strobe(5'b00000, 5'b10000, 8);             // occ[4] = 8
    check("t6_af_h9", almost_full[4], 1'b0);
    d1_h = 5'd8;
    tick();
    check("t6_af_h8", almost_full[4], 1'b1);
    vc1_h = 5'd17;                             // above DEPTH, occ[2] = 16
    tick();
    check("t6_h_above_depth", almost_full[2], 1'b0);
    vc1_l = 5'd16;                             // low at DEPTH
    tick();
    check("t6_l_at_depth", almost_empty[2], 1'b1);
    do_h = 5'd0;                               // occ[3] = 0
    tick();
    check("t6_h_zero", almost_full[3], 1'b1);
    d1_l = 5'd10;                              // low >= high, occ[4] = 8
    tick();
    check("t6_both_ae", almost_empty[4], 1'b1);
    check("t6_both_af", almost_full[4],  1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
